// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - issue/writeback sequencer around an external 16-bit ALU
// Accepts one op, drives the ALU from registered operands, returns the result and writes it back on handshake.
module alu_issue_seq #(
    parameter int REG_COUNT = 8,
    parameter int PC_INC    = 2,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [3:0]    req_func4_i,
    input  logic [AW-1:0] req_rd_i,
    input  logic [AW-1:0] req_rs1_i,
    input  logic [AW-1:0] req_rs2_i,
    input  logic [15:0]   req_imm_i,
    input  logic          req_imm_en_i,
    input  logic          req_jalr_i,
    input  logic [15:0]   req_pc_i,
    output logic [15:0]   rs1_data_o,
    output logic [15:0]   rs2_data_o,
    output logic [15:0]   imm_data_o,
    output logic          imm_en_o,
    output logic [3:0]    func4_o,
    output logic          jalr_en_o,
    input  logic [15:0]   alu_data_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [15:0]   rsp_data_o,
    output logic [AW-1:0] rsp_rd_o,
    output logic          rsp_jump_o,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [15:0]   dbg_data_o
);

    localparam logic [15:0] LP_PC_INC = 16'(PC_INC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_capture;
    logic            w_write;

    logic [3:0]      r_func4;
    logic [15:0]     r_imm;
    logic            r_imm_en;
    logic            r_jalr;
    logic [AW-1:0]   r_rd;
    logic [15:0]     r_pc;
    logic [15:0]     r_rs1;
    logic [15:0]     r_rs2;
    logic [15:0]     r_result;
    logic [15:0]     r_link;
    logic [15:0]     r_regs [REG_COUNT];

    logic [15:0]     w_rs1_val;
    logic [15:0]     w_rs2_val;

    // Register 0 is hardwired to zero on every read port.
    assign w_rs1_val  = (req_rs1_i  == '0) ? 16'h0000 : r_regs[req_rs1_i];
    assign w_rs2_val  = (req_rs2_i  == '0) ? 16'h0000 : r_regs[req_rs2_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? 16'h0000 : r_regs[dbg_addr_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_accept = 1'b1;
                    w_next   = EXEC;
                end
            end
            EXEC: begin
                w_capture = 1'b1;
                w_next    = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_write = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_func4  <= '0;
            r_imm    <= '0;
            r_imm_en <= 1'b0;
            r_jalr   <= 1'b0;
            r_rd     <= '0;
            r_pc     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_result <= '0;
            r_link   <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_func4  <= req_func4_i;
                r_imm    <= req_imm_i;
                r_imm_en <= req_imm_en_i;
                r_jalr   <= req_jalr_i;
                r_rd     <= req_rd_i;
                r_pc     <= req_pc_i;
                r_rs1    <= w_rs1_val;
                r_rs2    <= w_rs2_val;
            end
            if (w_capture) begin
                r_result <= alu_data_i;
                r_link   <= r_pc + LP_PC_INC;
            end
            // Writeback lands before the next accept, so dependent ops need no forwarding.
            if (w_write && (r_rd != '0)) begin
                r_regs[r_rd] <= r_jalr ? r_link : r_result;
            end
        end
    end

    assign rs1_data_o = r_rs1;
    assign rs2_data_o = r_rs2;
    assign imm_data_o = r_imm;
    assign imm_en_o   = r_imm_en;
    assign func4_o    = r_func4;
    assign jalr_en_o  = r_jalr;
    assign rsp_data_o = r_result;
    assign rsp_rd_o   = r_rd;
    assign rsp_jump_o = r_jalr;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - self-checking bench for alu_issue_seq with a behavioural ALU and register model
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_func4;
    logic [2:0]  req_rd, req_rs1, req_rs2;
    logic [15:0] req_imm;
    logic        req_imm_en, req_jalr;
    logic [15:0] req_pc;
    logic [15:0] rs1_data, rs2_data, imm_data;
    logic        imm_en;
    logic [3:0]  func4;
    logic        jalr_en;
    logic [15:0] alu_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_rd;
    logic        rsp_jump;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] m_regs [8];

    always #5 clk = ~clk;

    // Bench-side ALU: 0 ADD, 1 SUB, 2 SLTU, 3 AND, 4 OR, 5 XOR; JALR gives (a+b) with bit 0 cleared.
    function automatic logic [15:0] alu_f(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                          input logic j);
        logic [15:0] r;
        case (f)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = (a < b) ? 16'd1 : 16'd0;
            4'd3:    r = a & b;
            4'd4:    r = a | b;
            4'd5:    r = a ^ b;
            default: r = a + b;
        endcase
        if (j) r = (a + b) & 16'hFFFE;
        return r;
    endfunction

    assign alu_data = alu_f(func4, rs1_data, imm_en ? imm_data : rs2_data, jalr_en);

    alu_issue_seq dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_func4_i(req_func4), .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
        .req_imm_i(req_imm), .req_imm_en_i(req_imm_en), .req_jalr_i(req_jalr), .req_pc_i(req_pc),
        .rs1_data_o(rs1_data), .rs2_data_o(rs2_data), .imm_data_o(imm_data), .imm_en_o(imm_en),
        .func4_o(func4), .jalr_en_o(jalr_en), .alu_data_i(alu_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_rd_o(rsp_rd), .rsp_jump_o(rsp_jump),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
    );

    // Entered and left at 1-2 time units after a rising edge with the DUT idle.
    task automatic run_op(input logic [3:0] f, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [15:0] imm, input logic ie, input logic j, input logic [15:0] pc,
                          input int stall, input logic pulse);
        logic [15:0] a, b, exp_res, exp_wb, old_rd;
        a       = (rs1 == 3'd0) ? 16'h0 : m_regs[rs1];
        b       = ie ? imm : ((rs2 == 3'd0) ? 16'h0 : m_regs[rs2]);
        exp_res = alu_f(f, a, b, j);
        exp_wb  = j ? 16'(pc + 16'd2) : exp_res;
        old_rd  = m_regs[rd];

        req_func4 = f; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_imm = imm; req_imm_en = ie; req_jalr = j; req_pc = pc; req_valid = 1'b1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL idle_ready: got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rs1_data !== a || func4 !== f || jalr_en !== j) begin
            miscompares++;
            $display("FAIL exec_drive: valid=%b ready=%b rs1=%h func=%h jalr=%b want 0 0 %h %h %b",
                     rsp_valid, req_ready, rs1_data, func4, jalr_en, a, f, j);
        end
        @(posedge clk); #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_res || rsp_rd !== rd || rsp_jump !== j) begin
            miscompares++;
            $display("FAIL resp: valid=%b data=%h rd=%0d jump=%b want 1 %h %0d %b",
                     rsp_valid, rsp_data, rsp_rd, rsp_jump, exp_res, rd, j);
        end
        dbg_addr = rd;
        for (int s = 0; s < stall; s++) begin
            if (pulse && s == 0) req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_res || rsp_rd !== rd || req_ready !== 1'b0
                || dbg_data !== old_rd) begin
                miscompares++;
                $display("FAIL stall_hold: valid=%b data=%h ready=%b dbg=%h want 1 %h 0 %h",
                         rsp_valid, rsp_data, req_ready, dbg_data, exp_res, old_rd);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (rd != 3'd0) m_regs[rd] = exp_wb;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || dbg_data !== m_regs[rd]) begin
            miscompares++;
            $display("FAIL writeback r%0d: valid=%b ready=%b dbg=%h want 0 1 %h",
                     rd, rsp_valid, req_ready, dbg_data, m_regs[rd]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            vectors++;
            if (dbg_data !== 16'h0) begin
                miscompares++; $display("FAIL reset_reg r%0d: got %h want 0000", i, dbg_data);
            end
        end
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rs1_data !== 16'h0 || rs2_data !== 16'h0
            || imm_data !== 16'h0 || imm_en !== 1'b0 || func4 !== 4'h0 || jalr_en !== 1'b0
            || rsp_data !== 16'h0 || rsp_rd !== 3'd0 || rsp_jump !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b valid=%b rs1=%h rs2=%h imm=%h ie=%b f=%h j=%b rsp=%h want 1 0 all-zero",
                     req_ready, rsp_valid, rs1_data, rs2_data, imm_data, imm_en, func4, jalr_en, rsp_data);
        end
    endtask

    task automatic test_add_chain();
        run_op(4'd0, 3'd1, 3'd0, 3'd0, 16'd5, 1'b1, 1'b0, 16'h0, 0, 1'b0);
        run_op(4'd0, 3'd2, 3'd1, 3'd1, 16'h0, 1'b0, 1'b0, 16'h0, 0, 1'b0);
        vectors++;
        if (m_regs[2] !== 16'd10) begin
            miscompares++; $display("FAIL add_chain_model: got %h want 000a", m_regs[2]);
        end
    endtask

    task automatic test_sub_slt();
        run_op(4'd1, 3'd3, 3'd0, 3'd0, 16'd1, 1'b1, 1'b0, 16'h0, 0, 1'b0);
        run_op(4'd2, 3'd7, 3'd1, 3'd3, 16'h0, 1'b0, 1'b0, 16'h0, 0, 1'b0);
    endtask

    task automatic test_jalr();
        run_op(4'd0, 3'd4, 3'd1, 3'd0, 16'd4, 1'b1, 1'b1, 16'h0100, 0, 1'b0);
        dbg_addr = 3'd4;
        #1;
        vectors++;
        if (dbg_data !== 16'h0102) begin
            miscompares++; $display("FAIL jalr_link: got %h want 0102", dbg_data);
        end
    endtask

    task automatic test_stall();
        run_op(4'd0, 3'd5, 3'd2, 3'd1, 16'h0, 1'b0, 1'b0, 16'h0, 5, 1'b1);
    endtask

    task automatic test_rd0();
        run_op(4'd0, 3'd0, 3'd2, 3'd0, 16'h1234, 1'b1, 1'b0, 16'h0, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_op(4'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                   16'($urandom), $urandom_range(0, 2), 1'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            vectors++;
            if (dbg_data !== m_regs[i]) begin
                miscompares++; $display("FAIL random_regfile r%0d: got %h want %h", i, dbg_data, m_regs[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        req_func4 = 4'd0; req_rd = 3'd6; req_rs1 = 3'd1; req_rs2 = 3'd0;
        req_imm = 16'd7; req_imm_en = 1'b1; req_jalr = 1'b0; req_pc = 16'h0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rs1_data !== 16'h0 || imm_data !== 16'h0) begin
            miscompares++;
            $display("FAIL midreset_async: valid=%b ready=%b rs1=%h imm=%h want 0 1 0000 0000",
                     rsp_valid, req_ready, rs1_data, imm_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 16'h0) begin
            miscompares++;
            $display("FAIL midreset_idle: valid=%b ready=%b data=%h want 0 1 0000", rsp_valid, req_ready, rsp_data);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            vectors++;
            if (dbg_data !== m_regs[i]) begin
                miscompares++; $display("FAIL midreset_reg r%0d: got %h want %h", i, dbg_data, m_regs[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; dbg_addr = 3'd0;
        req_func4 = 4'd0; req_rd = 3'd0; req_rs1 = 3'd0; req_rs2 = 3'd0;
        req_imm = 16'h0; req_imm_en = 1'b0; req_jalr = 1'b0; req_pc = 16'h0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_add_chain();
        test_sub_slt();
        test_jalr();
        test_stall();
        test_rd0();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
